// File: rtl/parity_out_ctrl_if.sv
// Handshake bundle for parity_out_ctrl.
//   start/parity_in/in_ready : frame input from the encoder core
//   abort                    : synchronous frame abort
//   out_data/out_valid/out_ready/out_last : byte stream to downstream
// master = encoder core + downstream side, slave = parity_out_ctrl.
interface parity_out_ctrl_if #(
    parameter int N_BITS = 1024,
    parameter int BYTE_W = 8
);
    logic              start;
    logic [N_BITS-1:0] parity_in;
    logic              in_ready;
    logic              abort;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output start, parity_in, abort, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  start, parity_in, abort, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/parity_out_ctrl.sv
// parity_out_ctrl: streams a latched parity vector downstream one byte per
// valid/ready transfer, LSB byte first, driving an external byte counter.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : start/parity_in/in_ready, abort, out_* byte stream
//   en_counterOUT    : byte counter increment (one per transfer)
//   rst_c            : byte counter synchronous clear, active-low
//   parity_out_done  : byte counter reached N_BYTES; ends the frame
//   frame_done       : one-cycle pulse on frame completion
//   proto_err        : sticky; own byte index disagrees with the counter
module parity_out_ctrl #(
    parameter int N_BITS  = 1024,
    parameter int BYTE_W  = 8,
    parameter int N_BYTES = N_BITS / BYTE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_out_ctrl_if.slave   bus,
    output logic               en_counterOUT,
    output logic               rst_c,
    input  logic               parity_out_done,
    output logic               frame_done,
    output logic               proto_err
);
    localparam int IDX_W = $clog2(N_BYTES);

    // S_CLR is the abort path: one counter-clear cycle, then back to idle.
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE, S_CLR} state_t;

    state_t            state, nxt;
    logic [N_BITS-1:0] shreg;
    logic [IDX_W-1:0]  byte_idx;
    logic              sent_all;   // all N_BYTES transferred this frame
    logic              post_wait;  // one cycle already elapsed after sent_all without done
    logic              abort_act;
    logic              xfer;

    assign abort_act     = bus.abort && (state != S_IDLE);
    assign bus.in_ready  = (state == S_IDLE);
    // Abort suppresses valid so no byte is handed over in the abort cycle.
    assign bus.out_valid = (state == S_STREAM) && !parity_out_done && !abort_act;
    assign bus.out_data  = shreg[BYTE_W-1:0];
    assign bus.out_last  = (byte_idx == IDX_W'(N_BYTES - 1)) && bus.out_valid;
    assign xfer          = bus.out_valid && bus.out_ready;
    assign en_counterOUT = xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        rst_c      = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE:   if (bus.start) nxt = S_LOAD;
            S_LOAD:   begin rst_c = 1'b0; nxt = S_STREAM; end
            S_STREAM: if (parity_out_done) nxt = S_DONE;
            S_DONE:   begin frame_done = 1'b1; nxt = S_IDLE; end
            S_CLR:    begin rst_c = 1'b0; nxt = S_IDLE; end
            default:  nxt = S_IDLE;
        endcase
        if (abort_act) begin
            nxt        = S_CLR;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            byte_idx  <= '0;
            sent_all  <= 1'b0;
            post_wait <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (abort_act)
                shreg <= '0;
            else if (state == S_IDLE && bus.start)
                shreg <= bus.parity_in;
            else if (xfer)
                shreg <= shreg >> BYTE_W;

            if (state == S_LOAD) begin
                byte_idx  <= '0;
                sent_all  <= 1'b0;
                post_wait <= 1'b0;
            end else if (!abort_act) begin
                if (xfer) begin
                    byte_idx <= (byte_idx == IDX_W'(N_BYTES - 1)) ? '0 : byte_idx + 1'b1;
                    if (byte_idx == IDX_W'(N_BYTES - 1)) sent_all <= 1'b1;
                end
                if (state == S_STREAM && sent_all && !parity_out_done)
                    post_wait <= 1'b1;
            end

            // Counter ended early, or is still short two cycles after the last byte.
            if (state == S_STREAM && !abort_act &&
                ((parity_out_done && !sent_all) ||
                 (sent_all && !parity_out_done && post_wait)))
                proto_err <= 1'b1;
        end
    end
endmodule
